bch_encoder_15_7: RTL
=====================

# bch_encoder_15_7

Serial systematic encoder for the BCH(15,7) double-error-correcting code over GF(2^4), primitive polynomial x^4+x+1. It is the transmit-side counterpart of the BCH(15,7) syndrome/decoder path. It accepts a 7-bit message over a valid/ready handshake and computes the 8 parity bits with a bit-serial LFSR, one message bit per cycle. It then presents the 15-bit codeword over a second valid/ready handshake. Bit i of the codeword is the coefficient of x^i, the same bit ordering the syndrome logic uses for its `received` input.

## Interface
- PARITY_POLY, 8'hD1, coefficients x^7..x^0 of g(x) = x^8+x^7+x^6+x^4+1, with the x^8 term implied.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- msg_valid  input  1  message available.
- msg_ready  output  1  encoder can accept a message; high only in IDLE.
- msg  input  7  message; msg[j] is the coefficient of x^(j+8) in the codeword.
- cw_valid  output  1  codeword available; high only in DONE.
- cw_ready  input  1  downstream accepts the codeword.
- codeword  output  15  {message[6:0], parity[7:0]}.
- busy  output  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - msg_ready=1.
  - On msg_valid&&msg_ready: latch msg into msg_reg, clear parity p[7:0] to 0, clear bit counter cnt (3 bits) to 0, go to SHIFT.
- SHIFT: process msg_reg[6-cnt] as bit b, highest degree first.
  - fb = b ^ p[7].
  - p <= {p[6:0],1'b0} ^ ({8{fb}} & PARITY_POLY).
  - cnt <= cnt+1.
  - After the step with cnt==6, go to DONE.
  - cnt never exceeds 6.
- DONE:
  - cw_valid=1.
  - codeword={msg_reg,p} stays stable until accepted.
  - On cw_ready: go to IDLE.
- Inputs:
  - msg and msg_valid are ignored outside IDLE; msg_ready=0 there.
  - msg may change after acceptance without affecting the result.
- Result: p = (x^8·m(x)) mod g(x), so the codeword is a multiple of g(x) and all three syndromes of an error-free codeword are zero.
- Reset, at any time including mid-SHIFT or in DONE:
  - state=IDLE, p=0, msg_reg=0, cnt=0.
  - msg_ready=1, cw_valid=0, busy=0, codeword=0.
  - Any in-flight message is discarded and no partial codeword is emitted.
- Reset values hold for as long as rst is asserted.

## Timing
- Message accepted at edge E.
- SHIFT steps occur at edges E+1 through E+7.
- cw_valid rises after edge E+7, i.e. 7 cycles from acceptance.
- Codeword transfers at the first edge F ≥ E+8 with cw_valid&&cw_ready.
  - With cw_ready held high, that edge is E+8.
  - msg_ready=1 from edge F on, and the next message can be accepted at F+1.
- Maximum throughput: one codeword per 9 cycles.
- cw_ready low in DONE: hold indefinitely, with codeword and cw_valid unchanged.
- msg_ready and cw_valid are never high in the same cycle.
- All outputs are registered or decoded directly from the state registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then msg=7'h00 with cw_ready=1 -> cw_valid exactly 7 cycles after acceptance, codeword=15'h0000.
- msg=7'h01 -> codeword=15'h01D1; msg=7'h02 -> codeword=15'h0273.
- msg=7'h7F -> codeword=15'h7FFF, the all-ones codeword.
- Exhaustive backpressure run:
  - All 128 messages, with cw_ready randomly low for 0-20 cycles.
  - Each codeword must equal the reference polynomial division.
  - Each codeword fed to the syndrome block must give syndrome1=syndrome2=syndrome3=4'h0.
  - Codeword stable while stalled; msg_ready=0 throughout SHIFT and DONE.
- Assert rst mid-SHIFT (cnt=3) and separately in DONE -> all outputs go to reset values immediately (asynchronous). After release, a new msg=7'h01 still yields 15'h01D1.
- Back-to-back stream with msg_valid and cw_ready tied high -> one codeword every 9 cycles, no message dropped or duplicated.

Source files
------------

// File: rtl/bch_encoder_15_7_if.sv
// Message and codeword handshake bundle for the BCH(15,7) encoder.
// The encoder takes the slave view; the producer/consumer side takes the master view.
interface bch_encoder_15_7_if;
    logic        msg_valid;
    logic        msg_ready;
    logic [6:0]  msg;
    logic        cw_valid;
    logic        cw_ready;
    logic [14:0] codeword;

    modport master (
        output msg_valid,
        output msg,
        output cw_ready,
        input  msg_ready,
        input  cw_valid,
        input  codeword
    );

    modport slave (
        input  msg_valid,
        input  msg,
        input  cw_ready,
        output msg_ready,
        output cw_valid,
        output codeword
    );
endinterface

// File: rtl/bch_encoder_15_7.sv
// Bit-serial systematic BCH(15,7) encoder over GF(2^4): parity = x^8*m(x) mod g(x),
// one message bit per cycle, codeword = {msg, parity} with bit i the coefficient of x^i.
module bch_encoder_15_7 #(
    parameter logic [7:0] PARITY_POLY = 8'hD1
) (
    input  logic                 clk,
    input  logic                 rst,
    bch_encoder_15_7_if.slave    bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [6:0]  msg_reg, msg_reg_next;
    logic [7:0]  p, p_next;
    logic [2:0]  cnt, cnt_next;
    logic        b;
    logic        fb;

    // Both handshakes: a transfer happens on a rising edge where valid && ready.
    // valid/ready are decoded from state only, so no input reaches an output
    // combinationally; msg_ready and cw_valid are mutually exclusive.
    assign bus.msg_ready = (state == IDLE);
    assign bus.cw_valid  = (state == DONE);
    assign bus.codeword  = {msg_reg, p};
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

    // Highest-degree message bit enters the divider first.
    assign b  = msg_reg[3'd6 - cnt];
    assign fb = b ^ p[7];

    always_comb begin
        state_next   = state;
        msg_reg_next = msg_reg;
        p_next       = p;
        cnt_next     = cnt;
        unique case (state)
            IDLE: begin
                if (bus.msg_valid) begin
                    msg_reg_next = bus.msg;
                    p_next       = 8'h00;
                    cnt_next     = 3'd0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                p_next = {p[6:0], 1'b0} ^ ({8{fb}} & PARITY_POLY);
                if (cnt == 3'd6) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            DONE: begin
                if (bus.cw_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            msg_reg <= 7'h00;
            p       <= 8'h00;
            cnt     <= 3'd0;
        end else begin
            state   <= state_next;
            msg_reg <= msg_reg_next;
            p       <= p_next;
            cnt     <= cnt_next;
        end
    end

endmodule
